pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the ID-stage MIPS decoder: decodes opcode/func and registers the control bundle into the ID/EX boundary.
- Adds hazard detection: load-use stall, branch-operand stall, and branch/jump IF/ID flush.
- Tracks EX and MEM destination registers internally, so the datapath needs no separate hazard unit.
- Sits between the IF/ID pipeline register and the ID/EX datapath register.

Parameters:
RA_W, 5, register-address width (rs/rt/rd/dest)
ALUOP_W, 3, ALU op width; all-ones = ALU nop
MUL_CYCLES, 4, EX occupancy of MULT (legal range 2..16; only used with CU_MULT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IF/ID instruction [31:26]
func  in  6  IF/ID instruction [5:0]
rs, rt, rd  in  RA_W each  IF/ID register fields
equal, not_equal  in  1 each  ID-stage register comparator results
nop_in  in  1  external bubble request for the current ID instruction
pc_write, ifid_write  out  1 each  enables for PC and IF/ID (0 = hold)
ifid_flush  out  1  clear IF/ID on next edge
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dest  out  1 each  registered ID/EX control
ex_alu_op  out  ALUOP_W  registered ALU op
ex_dest  out  RA_W  registered write-back register (rd for R-type, rt for LW, 0 otherwise)
mul_busy  out  1  MULT occupying EX

Behaviour:
- Reset (clk edge with rst=1): all ex_* = 0, ex_alu_op = all-ones, ex_dest = 0, MEM-stage tracking cleared, mul FSM IDLE, counter = 0.
- Combinational outputs after reset with no hazard: pc_write = ifid_write = 1, ifid_flush = 0, pc_src = 0.
- Decode:
  - R-type (opcode 0): ADD 100000 -> 000, SUB 100010 -> 001, AND 100100 -> 010, OR 100101 -> 011, SLT 101010 -> 100. reg_dest = 1, reg_write = 1.
  - Unknown func: bubble (all control 0, alu_op all-ones).
  - LW 100011: alu_src, mem_read, mem_to_reg, reg_write; alu_op 000.
  - SW 101011: alu_src, mem_write; alu_op 000.
  - BEQ 000100 / BNE 000101 / J 000010: no EX control.
  - Any other opcode: bubble.
- Uses-rt: R-type, SW, BEQ, BNE. Uses-rs: all decoded opcodes except J. Register 0 never matches.
- Load-use stall: EX holds LW with ex_dest matching a used source.
- Branch stall: BEQ/BNE with a source matching EX dest (reg_write=1) or MEM dest of a load. A branch after a load therefore stalls 2 cycles.
- On any stall: pc_write = ifid_write = 0, pc_src = 0, ifid_flush = 0, bubble written into ID/EX.
- Branch/jump resolved only when not stalled:
  - BEQ with equal, or BNE with not_equal: pc_src = 1, ifid_flush = 1.
  - J: pc_src = 2, ifid_flush = 1.
  - Branch/jump instruction itself enters ID/EX as a bubble.
- nop_in = 1: current instruction becomes a bubble; no branch/jump action; pc_write = ifid_write = 1.
- MEM-stage tracking captures EX reg_write/mem_read/dest each edge. It captures a bubble while EX is held.
- Priority, highest first: rst > mul_busy hold > load-use/branch stall > nop_in > normal decode.
- Latency: ID/EX outputs valid one edge after the instruction is presented. pc_src and flush are same-cycle combinational.

Optional Feature:
CU_MULT_EN
- Defined: func 011000 (MULT) decodes to alu_op 101, reg_dest = 1, reg_write = 1.
  - When MULT is captured into EX, counter loads MUL_CYCLES-1 and the FSM goes IDLE -> BUSY.
  - In BUSY: mul_busy = 1, the ID/EX register holds its value, pc_write = ifid_write = 0, no flush, pc_src = 0.
  - Counter decrements each edge; BUSY -> IDLE when it reaches 0. Total EX occupancy is MUL_CYCLES cycles.
  - rst mid-BUSY returns to IDLE immediately.
- Not defined: 011000 is an unknown func (bubble); mul_busy is tied to 0; no counter or FSM.

Test Plan:
- Reset then ADD (func 100000, rd = 3) -> next edge: ex_alu_op = 000, ex_reg_write = 1, ex_reg_dest = 1, ex_dest = 3; pc_write = 1.
- LW rt = 5, then ADD rs = 5 -> one cycle with pc_write = ifid_write = 0 and a bubble in ID/EX; ADD issues the following cycle.
- LW rt = 7, then BEQ rs = 7, equal = 1 -> two stall cycles with pc_src = 0; third cycle pc_src = 1, ifid_flush = 1.
- J with nop_in = 0 -> pc_src = 2, ifid_flush = 1, ID/EX bubble (ex_alu_op = 111). Same J with nop_in = 1 -> pc_src = 0, no flush.
- BNE with not_equal = 0 and no hazard -> pc_src = 0, no flush; LW rt = 0 followed by ADD rs = 0 -> no stall.
- CU_MULT_EN, MUL_CYCLES = 4: MULT -> mul_busy high for exactly 3 cycles after EX capture, ex_alu_op = 101 held. rst asserted in the 2nd busy cycle -> mul_busy = 0 and all ex_* reset values next cycle.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID decode into registered ID/EX control with load-use/branch stall and branch/jump flush; in: clk, rst, IF/ID opcode/func/rs/rt/rd, equal/not_equal, nop_in; out: pc_write, ifid_write, ifid_flush, pc_src, ex_* bundle, mul_busy; optional multi-cycle MULT under CU_MULT_EN
module pipe_ctrl_unit #(
  parameter int RA_W = 5,
  parameter int ALUOP_W = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic [RA_W-1:0]    rs,
  input  logic [RA_W-1:0]    rt,
  input  logic [RA_W-1:0]    rd,
  input  logic               equal,
  input  logic               not_equal,
  input  logic               nop_in,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic [1:0]         pc_src,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic               ex_reg_dest,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [RA_W-1:0]    ex_dest,
  output logic               mul_busy
);
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dest;
    logic [ALUOP_W-1:0] alu_op;
    logic [RA_W-1:0] dest;
  } ctrl_t;
  localparam ctrl_t BUBBLE = ctrl_t'({6'b0, {ALUOP_W{1'b1}}, {RA_W{1'b0}}});
  ctrl_t d, ex, nxt;
  logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, r_ok, uses_rs, uses_rt;
  logic rs_ex, rt_ex, rs_mem, rt_mem, hold, load_use, br_stall, stall, take;
  logic [ALUOP_W-1:0] r_op;
  logic mem_rd;
  logic [RA_W-1:0] mem_dest;
  assign is_r   = opcode == 6'b000000;
  assign is_lw  = opcode == 6'b100011;
  assign is_sw  = opcode == 6'b101011;
  assign is_beq = opcode == 6'b000100;
  assign is_bne = opcode == 6'b000101;
  assign is_j   = opcode == 6'b000010;
  assign uses_rs = is_r || is_lw || is_sw || is_beq || is_bne;
  assign uses_rt = is_r || is_sw || is_beq || is_bne;
  always_comb begin
    r_ok = 1'b1;
    case (func)
      6'b100000: r_op = ALUOP_W'(0);
      6'b100010: r_op = ALUOP_W'(1);
      6'b100100: r_op = ALUOP_W'(2);
      6'b100101: r_op = ALUOP_W'(3);
      6'b101010: r_op = ALUOP_W'(4);
`ifdef CU_MULT_EN
      6'b011000: r_op = ALUOP_W'(5);
`endif
      default: begin
        r_op = '1;
        r_ok = 1'b0;
      end
    endcase
  end
  always_comb begin
    d = BUBBLE;
    if (is_r && r_ok) begin
      d.reg_write = 1'b1;
      d.reg_dest  = 1'b1;
      d.alu_op    = r_op;
      d.dest      = rd;
    end
    if (is_lw) begin
      d.reg_write  = 1'b1;
      d.mem_read   = 1'b1;
      d.mem_to_reg = 1'b1;
      d.alu_src    = 1'b1;
      d.alu_op     = '0;
      d.dest       = rt;
    end
    if (is_sw) begin
      d.mem_write = 1'b1;
      d.alu_src   = 1'b1;
      d.alu_op    = '0;
    end
  end
  assign rs_ex  = uses_rs && rs != '0 && rs == ex.dest;
  assign rt_ex  = uses_rt && rt != '0 && rt == ex.dest;
  assign rs_mem = uses_rs && rs != '0 && rs == mem_dest;
  assign rt_mem = uses_rt && rt != '0 && rt == mem_dest;
  assign hold     = mul_busy;
  assign load_use = ex.mem_read && (rs_ex || rt_ex);
  // branches compare in ID, so they also wait on ALU results in EX and loads still in MEM
  assign br_stall = (is_beq || is_bne) && ((ex.reg_write && (rs_ex || rt_ex)) || (mem_rd && (rs_mem || rt_mem)));
  assign stall    = !hold && (load_use || br_stall);
  assign take     = !hold && !stall && !nop_in && ((is_beq && equal) || (is_bne && not_equal) || is_j);
  assign pc_write   = !(hold || stall);
  assign ifid_write = pc_write;
  assign ifid_flush = take;
  assign pc_src     = take ? (is_j ? 2'd2 : 2'd1) : 2'd0;
  assign nxt        = (stall || nop_in) ? BUBBLE : d;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex       <= BUBBLE;
      mem_rd   <= 1'b0;
      mem_dest <= '0;
    end else begin
      mem_rd   <= !hold && ex.mem_read;
      mem_dest <= hold ? '0 : ex.dest;
      if (!hold) ex <= nxt;
    end
  end
  assign ex_reg_write  = ex.reg_write;
  assign ex_mem_read   = ex.mem_read;
  assign ex_mem_write  = ex.mem_write;
  assign ex_mem_to_reg = ex.mem_to_reg;
  assign ex_alu_src    = ex.alu_src;
  assign ex_reg_dest   = ex.reg_dest;
  assign ex_alu_op     = ex.alu_op;
  assign ex_dest       = ex.dest;
`ifdef CU_MULT_EN
  localparam int CW = $clog2(MUL_CYCLES);
  typedef enum logic {IDLE, BUSY} mstate_t;
  mstate_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end
  // the capture edge counts as the first EX cycle, so BUSY spans MUL_CYCLES-1 more
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    if (st == BUSY) begin
      cnt_n = cnt - 1'b1;
      st_n  = (cnt_n == '0) ? IDLE : BUSY;
    end else if (!stall && !nop_in && is_r && func == 6'b011000) begin
      cnt_n = CW'(MUL_CYCLES - 1);
      st_n  = BUSY;
    end
  end
  assign mul_busy = st == BUSY;
`else
  assign mul_busy = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed scoreboard bench for pipe_ctrl_unit (MULT steps follow CU_MULT_EN)
module tb_pipe_ctrl_unit;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_MULT = 6'b011000, F_BAD = 6'b000111;
  localparam logic [5:0] RUN = 6'b110000, STL = 6'b000000, BR = 6'b111010, JMP = 6'b111100, BSY = 6'b000001;
  typedef logic [13:0] exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, func = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic equal = 1'b0, not_equal = 1'b0, nop_in = 1'b0;
  logic pc_write, ifid_write, ifid_flush, mul_busy;
  logic [1:0] pc_src;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dest;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_dest;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  pipe_ctrl_unit #(.RA_W(5), .ALUOP_W(3), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .equal(equal), .not_equal(not_equal), .nop_in(nop_in),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .pc_src(pc_src),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_dest(ex_reg_dest),
    .ex_alu_op(ex_alu_op), .ex_dest(ex_dest), .mul_busy(mul_busy)
  );
  always #5 clk = ~clk;
  wire [5:0] cobs = {pc_write, ifid_write, ifid_flush, pc_src, mul_busy};
  wire exp_t obs = {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dest, ex_alu_op, ex_dest};
  function automatic exp_t bub();
    return {6'b000000, 3'b111, 5'd0};
  endfunction
  function automatic exp_t rtype(input logic [2:0] op, input logic [4:0] dst);
    return {6'b100001, op, dst};
  endfunction
  function automatic exp_t lw(input logic [4:0] dst);
    return {6'b110110, 3'b000, dst};
  endfunction
  function automatic exp_t sw();
    return {6'b001010, 3'b000, 5'd0};
  endfunction
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] s, input logic [4:0] t, input logic [4:0] dst,
                      input logic eq, input logic ne, input logic nop,
                      input logic [5:0] ec, input exp_t e);
    exp_t got;
    opcode = op; func = fn; rs = s; rt = t; rd = dst;
    equal = eq; not_equal = ne; nop_in = nop;
    #2;
    chk({tag, ".ctl"}, 16'(cobs), 16'(ec));
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    chk({tag, ".idex"}, 16'(obs), 16'(got));
  endtask
  initial begin
    @(posedge clk); #1;
    chk("reset.idex", 16'(obs), 16'(bub()));
    rst = 1'b0;
    step("idle",     OP_R,   6'd0,  0, 0, 0, 0, 0, 0, RUN, bub());
    step("add",      OP_R,   F_ADD, 1, 2, 3, 0, 0, 0, RUN, rtype(3'b000, 3));
    step("lw5",      OP_LW,  6'd0,  1, 5, 0, 0, 0, 0, RUN, lw(5));
    step("lu_stall", OP_R,   F_ADD, 5, 2, 4, 0, 0, 0, STL, bub());
    step("lu_issue", OP_R,   F_ADD, 5, 2, 4, 0, 0, 0, RUN, rtype(3'b000, 4));
    step("lw7",      OP_LW,  6'd0,  1, 7, 0, 0, 0, 0, RUN, lw(7));
    step("br_st1",   OP_BEQ, 6'd0,  7, 2, 0, 1, 0, 0, STL, bub());
    step("br_st2",   OP_BEQ, 6'd0,  7, 2, 0, 1, 0, 0, STL, bub());
    step("br_take",  OP_BEQ, 6'd0,  7, 2, 0, 1, 0, 0, BR,  bub());
    step("j",        OP_J,   6'd0,  0, 0, 0, 0, 0, 0, JMP, bub());
    step("j_nop",    OP_J,   6'd0,  0, 0, 0, 0, 0, 1, RUN, bub());
    step("bne_nt",   OP_BNE, 6'd0,  1, 2, 0, 0, 0, 0, RUN, bub());
    step("bne_t",    OP_BNE, 6'd0,  1, 2, 0, 0, 1, 0, BR,  bub());
    step("beq_nt",   OP_BEQ, 6'd0,  1, 2, 0, 0, 1, 0, RUN, bub());
    step("sw",       OP_SW,  6'd0,  1, 2, 0, 0, 0, 0, RUN, sw());
    step("sub",      OP_R,   F_SUB, 1, 2, 6, 0, 0, 0, RUN, rtype(3'b001, 6));
    step("and",      OP_R,   F_AND, 1, 2, 8, 0, 0, 0, RUN, rtype(3'b010, 8));
    step("or",       OP_R,   F_OR,  1, 2, 9, 0, 0, 0, RUN, rtype(3'b011, 9));
    step("slt",      OP_R,   F_SLT, 1, 2, 5, 0, 0, 0, RUN, rtype(3'b100, 5));
    step("lw0",      OP_LW,  6'd0,  1, 0, 0, 0, 0, 0, RUN, lw(0));
    step("r0_nostl", OP_R,   F_ADD, 0, 0, 9, 0, 0, 0, RUN, rtype(3'b000, 9));
    step("add10",    OP_R,   F_ADD, 1, 2, 10, 0, 0, 0, RUN, rtype(3'b000, 10));
    step("br_exst",  OP_BEQ, 6'd0,  10, 2, 0, 1, 0, 0, STL, bub());
    step("br_exgo",  OP_BEQ, 6'd0,  10, 2, 0, 1, 0, 0, BR,  bub());
    step("bad_op",   OP_BAD, F_ADD, 1, 2, 3, 0, 0, 0, RUN, bub());
    step("bad_fn",   OP_R,   F_BAD, 1, 2, 3, 0, 0, 0, RUN, bub());
    step("nop_add",  OP_R,   F_ADD, 1, 2, 3, 0, 0, 1, RUN, bub());
    step("lw11",     OP_LW,  6'd0,  1, 11, 0, 0, 0, 0, RUN, lw(11));
    step("stl_nop",  OP_R,   F_ADD, 11, 2, 12, 0, 0, 1, STL, bub());
    step("after",    OP_R,   F_ADD, 11, 2, 12, 0, 0, 0, RUN, rtype(3'b000, 12));
`ifdef CU_MULT_EN
    step("mult",     OP_R,   F_MULT, 1, 2, 12, 0, 0, 0, RUN, rtype(3'b101, 12));
    step("busy1",    OP_R,   F_ADD, 1, 2, 13, 0, 0, 0, BSY, rtype(3'b101, 12));
    step("busy2",    OP_R,   F_ADD, 1, 2, 13, 0, 0, 0, BSY, rtype(3'b101, 12));
    step("busy3",    OP_R,   F_ADD, 1, 2, 13, 0, 0, 0, BSY, rtype(3'b101, 12));
    step("post_mul", OP_R,   F_ADD, 1, 2, 13, 0, 0, 0, RUN, rtype(3'b000, 13));
    step("mult2",    OP_R,   F_MULT, 1, 2, 14, 0, 0, 0, RUN, rtype(3'b101, 14));
    step("m2busy1",  OP_R,   F_ADD, 1, 2, 13, 0, 0, 0, BSY, rtype(3'b101, 14));
    rst = 1'b1;
    #2;
    chk("m2busy2.ctl", 16'(cobs), 16'(BSY));
    @(posedge clk); #1;
    chk("mrst.idex", 16'(obs), 16'(bub()));
    chk("mrst.ctl", 16'(cobs), 16'(RUN));
    rst = 1'b0;
`else
    step("mult_off", OP_R,   F_MULT, 1, 2, 12, 0, 0, 0, RUN, bub());
`endif
    step("final",    OP_R,   F_ADD, 1, 2, 15, 0, 0, 0, RUN, rtype(3'b000, 15));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
